// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit holding HI/LO; result commits MULT_CYCLES/DIV_CYCLES after launch.
// Busy is high for exactly that many cycles; MDU instructions in D are stalled by the hazard unit meanwhile.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   stg_hi_q, stg_lo_q;
  logic          stg_wr_q;

  logic          is_mul, is_div, launch;
  logic [63:0]   a_sx, b_sx, prod_s, prod_u;
  logic [31:0]   dvs, quo_s, rem_s, quo_u, rem_u;
  logic          div_ovf;
  logic [31:0]   stg_hi_d, stg_lo_d;

  assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign launch = (state_q == S_IDLE) && Start && !req && (is_mul || is_div);

  always_comb begin
    a_sx    = {{32{A[31]}}, A};
    b_sx    = {{32{B[31]}}, B};
    prod_s  = a_sx * b_sx;
    prod_u  = {32'd0, A} * {32'd0, B};
    // Divisor forced to 1 on B==0 so the datapath stays defined; the commit is suppressed anyway.
    dvs     = (B == 32'd0) ? 32'd1 : B;
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(A) / $signed(dvs);
      rem_s = $signed(A) % $signed(dvs);
    end
    quo_u = A / dvs;
    rem_u = A % dvs;

    stg_hi_d = 32'd0;
    stg_lo_d = 32'd0;
    case (MDUOp)
      OP_MULT:  {stg_hi_d, stg_lo_d} = prod_s;
      OP_MULTU: {stg_hi_d, stg_lo_d} = prod_u;
      OP_DIV:   begin stg_hi_d = rem_s; stg_lo_d = quo_s; end
      OP_DIVU:  begin stg_hi_d = rem_u; stg_lo_d = quo_u; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      stg_hi_q <= 32'd0;
      stg_lo_q <= 32'd0;
      stg_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            stg_hi_q <= stg_hi_d;
            stg_lo_q <= stg_lo_d;
            stg_wr_q <= !(is_div && (B == 32'd0));
            cnt_q    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_q  <= S_BUSY;
          end else if (!req && (MDUOp == OP_MTHI)) begin
            hi_q <= A;
          end else if (!req && (MDUOp == OP_MTLO)) begin
            lo_q <= A;
          end
        end
        S_BUSY: begin
          // An in-flight op belongs to an older instruction, so req does not cancel it.
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (stg_wr_q) begin
              hi_q <= stg_hi_q;
              lo_q <= stg_lo_q;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy   = (state_q == S_BUSY);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = (MDUOp == OP_MFHI) ? hi_q :
                  (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO/busy-length per op, monitor checks on Busy fall.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic        Start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .MDUOp(MDUOp), .Start(Start),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    int          gap;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures busy length and idle gap, compares against the scoreboard on each completion.
  int   busy_len = 0;
  int   gap_cnt  = 0;
  int   last_gap = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      gap_cnt   = 0;
    end else begin
      if (Busy) begin
        if (!prev_busy) begin
          last_gap = gap_cnt;
          gap_cnt  = 0;
        end
        busy_len++;
      end else begin
        if (prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got HI=%h LO=%h expected no operation", HI, LO);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, HI, e.hi);
            chk({e.name, "_lo"}, LO, e.lo);
            chk({e.name, "_busy_len"}, 32'(busy_len), 32'(e.len));
            if (e.gap >= 0) chk({e.name, "_gap"}, 32'(last_gap), 32'(e.gap));
          end
          busy_len = 0;
          gap_cnt  = 0;
        end
        gap_cnt++;
      end
      prev_busy = Busy;
    end
  end

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input int len, input int gap);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    MDUOp = op; A = a; B = b; Start = st; req = rq;
    @(posedge clk); #1;
    MDUOp = 4'd0; Start = 1'b0; req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (Busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    MDUOp = 4'd5; #1;
    chk("rst_mfhi", MDUOut, 32'd0);
    MDUOp = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, -1);
    drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    wait_idle("mult");

    expect_op("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5, -1);
    drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    wait_idle("multu");

    expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, -1);
    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_idle("div_neg");

    expect_op("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, -1);
    drive(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
    wait_idle("divu_by0");

    expect_op("div_ovf", 32'd0, 32'h8000_0000, 10, -1);
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_idle("div_ovf");

    expect_op("divu", 32'd2, 32'd14, 10, -1);
    drive(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_idle("divu");

    expect_op("div_negb", 32'd1, 32'hFFFF_FFFD, 10, -1);
    drive(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_idle("div_negb");

    // mthi / mtlo / mfhi / mflo
    drive(4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    MDUOp = 4'd5; #1;
    chk("mfhi", MDUOut, 32'h1234_5678);
    MDUOp = 4'd0;
    drive(4'd8, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    MDUOp = 4'd6; #1;
    chk("mflo", MDUOut, 32'hCAFE_F00D);
    MDUOp = 4'd0;
    drive(4'd8, 32'h1111_1111, 32'd0, 1'b0, 1'b1);
    MDUOp = 4'd6; #1;
    chk("mtlo_req_blocked", MDUOut, 32'hCAFE_F00D);
    MDUOp = 4'd12; #1;
    chk("mduout_op12", MDUOut, 32'd0);
    MDUOp = 4'd0;

    // Launch cancelled by req
    drive(4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    chk("req_cancel_busy0", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    chk("req_cancel_busy1", 32'(Busy), 32'd0);
    chk("req_cancel_hi", HI, 32'h1234_5678);
    chk("req_cancel_lo", LO, 32'hCAFE_F00D);

    // req during an in-flight op does not cancel it
    expect_op("mult_req_mid", 32'd0, 32'd12, 5, -1);
    drive(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle("mult_req_mid");

    // mthi while busy is ignored (div-by-zero keeps HI/LO, so a stray write would show)
    expect_op("mthi_busy", 32'd0, 32'd12, 10, -1);
    drive(4'd4, 32'd5, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    MDUOp = 4'd7; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    MDUOp = 4'd0;
    wait_idle("mthi_busy");

    // Opcode 12 with Start does nothing
    drive(4'd12, 32'd1, 32'd1, 1'b1, 1'b0);
    chk("op12_busy", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    chk("op12_busy_later", 32'(Busy), 32'd0);

    // Back-to-back: div launched the cycle right after the mult commit
    expect_op("b2b_mult", 32'd1, 32'd0, 5, -1);
    expect_op("b2b_div", 32'd2, 32'hFFFF_FFF2, 10, 1);
    drive(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    wait_idle("b2b_mult");
    drive(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
    wait_idle("b2b_div");

    // Async reset mid-div at cnt=4 aborts the op
    drive(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b0; #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_busy_after", 32'(Busy), 32'd0);
    chk("abort_hi_after", HI, 32'd0);
    chk("abort_lo_after", LO, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
